rsa_decrypt: RTL and testbench

RSA decryption core: computes m = c^d mod n with a left-to-right square-and-multiply exponentiation over the private exponent d. It is the receive-side counterpart of the existing repeated-multiply encryption block and reuses the same `Mult` and `Divide` submodules for each modular multiply. Its default build is deliberately non-constant-time: it skips the multiply on zero exponent bits, giving a measurable timing side channel for the attack benches. A compile-time option makes it constant-time.

---
 rtl/rsa_decrypt.sv | 236 +++++++++++++++++++++++
 tb/tb_rsa_decrypt.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt.sv
// RSA decryption core: m = c^d mod n by left-to-right square-and-multiply over all 2*WIDTH bits of d.
// Define RSA_DEC_CONST_TIME_EN for a constant-time build (a multiply on every exponent bit).

module Mult #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   output logic [2*WIDTH-1:0] product,
   output logic               finish
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product <= '0;
         finish  <= 1'b0;
      end else begin
         finish <= start;
         if (start) product <= {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
      end
   end
endmodule

module Divide #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remainder,
   output logic             finish
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             run;
   logic [WIDTH:0]   shifted;
   logic             fits;

   // Restoring division: one quotient bit per cycle, MSB first.
   assign shifted = {remainder, quo[WIDTH-1]};
   assign fits    = shifted >= {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo       <= '0;
         dvs       <= '0;
         remainder <= '0;
         cnt       <= '0;
         run       <= 1'b0;
         finish    <= 1'b0;
      end else begin
         finish <= 1'b0;
         if (start) begin
            quo       <= dividend;
            dvs       <= divisor;
            remainder <= '0;
            cnt       <= CW'(WIDTH);
            run       <= 1'b1;
         end else if (run) begin
            remainder <= fits ? shifted[WIDTH-1:0] - dvs : shifted[WIDTH-1:0];
            quo       <= {quo[WIDTH-2:0], fits};
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               run    <= 1'b0;
               finish <= 1'b1;
            end
         end
      end
   end
endmodule

module rsa_decrypt #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] c,
   input  logic [2*WIDTH-1:0] d,
   input  logic [2*WIDTH-1:0] n,
   output logic [2*WIDTH-1:0] m,
   output logic               finish,
   output logic               busy,
   output logic [2*WIDTH-1:0] op_cnt
);
   localparam int W2 = 2 * WIDTH;
   localparam int W4 = 4 * WIDTH;
   localparam int IW = $clog2(W2);

`ifdef RSA_DEC_CONST_TIME_EN
   localparam bit CONST_TIME = 1'b1;
`else
   localparam bit CONST_TIME = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

   state_t        state, state_next;
   logic [W2-1:0] acc, acc_next;
   logic [W2-1:0] c_reg, c_next, d_reg, d_next, n_reg, n_next;
   logic [W2-1:0] m_next, op_next;
   logic [IW-1:0] idx, idx_next;
   logic          finish_next;
   logic          go, go_next;
   logic [W2-1:0] mult_in2;
   logic [W4-1:0] product, rem;
   logic          mult_finish, div_finish;
   logic [W2-1:0] rem_lo;
   logic          unused_rem_hi;

   // Remainder is always below n, so only the low half carries information.
   assign rem_lo        = rem[W2-1:0];
   assign unused_rem_hi = ^rem[W4-1:W2];
   assign mult_in2      = (state == MUL) ? c_reg : acc;
   assign busy          = (state != IDLE) || finish;

   Mult #(.WIDTH(W2)) u_mult (
      .clk     (clk),
      .rst_n   (~rst),
      .start   (go),
      .in1     (acc),
      .in2     (mult_in2),
      .product (product),
      .finish  (mult_finish)
   );

   Divide #(.WIDTH(W4)) u_div (
      .clk       (clk),
      .rst_n     (~rst),
      .start     (mult_finish),
      .dividend  (product),
      .divisor   ({{W2{1'b0}}, n_reg}),
      .remainder (rem),
      .finish    (div_finish)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= W2'(1);
         idx    <= '1;
         c_reg  <= '0;
         d_reg  <= '0;
         n_reg  <= '0;
         m      <= '0;
         op_cnt <= '0;
         finish <= 1'b0;
         go     <= 1'b0;
      end else begin
         state  <= state_next;
         acc    <= acc_next;
         idx    <= idx_next;
         c_reg  <= c_next;
         d_reg  <= d_next;
         n_reg  <= n_next;
         m      <= m_next;
         op_cnt <= op_next;
         finish <= finish_next;
         go     <= go_next;
      end
   end

   always_comb begin
      state_next  = state;
      acc_next    = acc;
      idx_next    = idx;
      c_next      = c_reg;
      d_next      = d_reg;
      n_next      = n_reg;
      m_next      = m;
      op_next     = op_cnt;
      finish_next = 1'b0;
      go_next     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !finish) begin
               c_next   = c;
               d_next   = d;
               n_next   = n;
               op_next  = '0;
               idx_next = '1;
               if (n[W2-1:1] == '0) begin
                  acc_next   = '0;
                  state_next = DONE;
               end else begin
                  acc_next   = W2'(1);
                  state_next = SQR;
                  go_next    = 1'b1;
               end
            end
         end
         SQR: begin
            if (div_finish) begin
               acc_next = rem_lo;
               op_next  = op_cnt + W2'(1);
               if (CONST_TIME || d_reg[idx]) begin
                  state_next = MUL;
                  go_next    = 1'b1;
               end else if (idx == '0) begin
                  state_next = DONE;
               end else begin
                  idx_next = idx - IW'(1);
                  go_next  = 1'b1;
               end
            end
         end
         MUL: begin
            if (div_finish) begin
               // In the constant-time build a zero bit still multiplies but discards the product.
               if (!CONST_TIME || d_reg[idx]) acc_next = rem_lo;
               op_next = op_cnt + W2'(1);
               if (idx == '0) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx - IW'(1);
                  state_next = SQR;
                  go_next    = 1'b1;
               end
            end
         end
         DONE: begin
            m_next      = acc;
            finish_next = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_rsa_decrypt.sv
// Randomized bench for rsa_decrypt: a modular-exponentiation model predicts m, op_cnt and latency.
module tb_rsa_decrypt;
   localparam int WIDTH = 8;
   localparam int W2    = 2 * WIDTH;
`ifdef RSA_DEC_CONST_TIME_EN
   localparam bit CT = 1'b1;
`else
   localparam bit CT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W2-1:0] c = '0, d = '0, n = '0;
   logic [W2-1:0] m, op_cnt;
   logic          finish, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int q_m[$], q_ops[$], q_t0[$];
   int hold_m   = 0;
   int period   = 0;
   int last_lat = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   rsa_decrypt #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .c      (c),
      .d      (d),
      .n      (n),
      .m      (m),
      .finish (finish),
      .busy   (busy),
      .op_cnt (op_cnt)
   );

   function automatic int model_m(input int cc, input int dd, input int nn);
      longint r;
      if (nn < 2) return 0;
      r = 1;
      for (int i = W2 - 1; i >= 0; i--) begin
         r = (r * r) % nn;
         if (dd[i]) r = (r * cc) % nn;
      end
      return int'(r);
   endfunction

   function automatic int model_ops(input int dd, input int nn);
      logic [W2-1:0] dv;
      dv = dd[W2-1:0];
      if (nn < 2) return 0;
      return CT ? 2 * W2 : W2 + $countones(dv);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic run(input int cc, input int dd, input int nn);
      @(negedge clk);
      c = cc[W2-1:0];
      d = dd[W2-1:0];
      n = nn[W2-1:0];
      start = 1'b1;
      q_m.push_back(model_m(cc, dd, nn));
      q_ops.push_back(model_ops(dd, nn));
      q_t0.push_back(cyc);
      $display("start c=%0d d=%0d n=%0d -> expect m=%0d ops=%0d", cc, dd, nn, q_m[$], q_ops[$]);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (q_m.size() > 0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (q_m.size() > 0) begin
         check("finish_timeout", 0, 1);
         q_m.delete(); q_ops.delete(); q_t0.delete();
      end
   endtask

   // Single compare process: busy, held m, and every finish against the model.
   always @(negedge clk) begin : compare
      int em, eo, t0;
      if (!rst) begin
         check("busy", int'(busy), (q_m.size() > 0 && cyc > q_t0[0]) ? 1 : 0);
         if (finish) begin
            if (q_m.size() == 0) begin
               check("unexpected_finish", 1, 0);
            end else begin
               em = q_m.pop_front();
               eo = q_ops.pop_front();
               t0 = q_t0.pop_front();
               last_lat = cyc - t0;
               check("m", int'(m), em);
               check("op_cnt", int'(op_cnt), eo);
               if (period > 0) check("latency", last_lat, 2 + eo * period);
               $display("finish m=%0d op_cnt=%0d latency=%0d", m, op_cnt, last_lat);
               hold_m = em;
            end
         end else begin
            check("m_hold", int'(m), hold_m);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat_a, lat_b, ops0, cc, dd, nn;
      // Pin the model with hand-known RSA values (n=61*53, e=17, d=2753).
      check("model_dec", model_m(2790, 2753, 3233), 65);
      check("model_enc", model_m(65, 17, 3233), 2790);
      check("model_ops", model_ops(2753, 3233), CT ? 32 : 21);

      repeat (3) @(negedge clk);
      check("rst_m", int'(m), 0);
      check("rst_finish", int'(finish), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_op_cnt", int'(op_cnt), 0);
      rst = 1'b0;

      // d=0 run also calibrates the per-multiply cost T+1.
      ops0 = model_ops(0, 3233);
      run(1234, 0, 3233);
      wait_done();
      check("d0_m", int'(m), 1);
      check("d0_ops", int'(op_cnt), CT ? 32 : 16);
      check("lat_divisible", (last_lat - 2) % ops0, 0);
      period = (last_lat - 2) / ops0;
      check("period_sane", (period > 1) ? 1 : 0, 1);

      run(2790, 2753, 3233);
      wait_done();
      check("vec_m", int'(m), 65);
      check("vec_ops", int'(op_cnt), CT ? 32 : 21);

      run(model_m(65, 17, 3233), 2753, 3233);
      wait_done();
      check("roundtrip_m", int'(m), 65);

      run(1234, 2753, 1);
      wait_done();
      check("n1_m", int'(m), 0);
      check("n1_ops", int'(op_cnt), 0);
      check("n1_latency", last_lat, 2);

      run(2790, 16'h8000, 3233);
      wait_done();
      lat_a = last_lat;
      check("leak_ops_a", int'(op_cnt), CT ? 32 : 17);
      run(2790, 16'hFFFF, 3233);
      wait_done();
      lat_b = last_lat;
      check("leak_ops_b", int'(op_cnt), 32);
      check("leak_delta", lat_b - lat_a, CT ? 0 : 15 * period);

      // Start pulsed mid-run with other operands must be ignored.
      run(2790, 2753, 3233);
      repeat (40) @(negedge clk);
      c = 16'd1; d = 16'hFFFF; n = 16'd77; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      check("ignore_start_m", int'(m), 65);

      // Reset mid-run aborts everything.
      run(1234, 16'hBEEF, 40009);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_m", int'(m), 0);
      check("midrst_finish", int'(finish), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_op_cnt", int'(op_cnt), 0);
      q_m.delete(); q_ops.delete(); q_t0.delete();
      hold_m = 0;
      @(negedge clk);
      rst = 1'b0;
      run(2790, 2753, 3233);
      wait_done();
      check("post_rst_m", int'(m), 65);

      for (int i = 0; i < 15; i++) begin
         cc = int'($urandom_range(0, 65535));
         dd = int'($urandom_range(0, 65535));
         nn = (i % 7 == 3) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 65535));
         run(cc, dd, nn);
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
